// File: rtl/sng_frame_gen.sv
// Binary-to-stochastic encoder. Each accepted WIDTH-bit value becomes a
// 2^WIDTH-bit unipolar stream. The final bit of the stream is flagged with out_last.
module sng_frame_gen #(
    parameter int          WIDTH = 8,
    parameter logic [15:0] SEED  = 16'h00F3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last
);

    // Feedback mask per width: tap n of the polynomial selects rng[n-1].
    function automatic logic [15:0] tap_mask16(input int w);
        logic [15:0] m;
        case (w)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0E08;
            13:      m = 16'h1C80;
            14:      m = 16'h3802;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h000C;
        endcase
        return m;
    endfunction

    localparam logic [15:0]      TAP16    = tap_mask16(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAP16[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED_W == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED_W;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_rng;
    logic [WIDTH-1:0] r_val;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_out_bit;
    logic             r_out_last;

    logic             w_transfer;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_lfsr;
    logic [WIDTH-1:0] w_rng_nxt;
    logic             w_last_nxt;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        w_transfer = r_out_valid && out_ready;
        w_cnt_nxt  = r_cnt + 1'b1;
        w_lfsr     = {r_rng[WIDTH-2:0], ^(r_rng & TAPS)};
        w_rng_nxt  = (r_cnt == '0) ? SEED_EFF : w_lfsr;
        w_last_nxt = (w_cnt_nxt == '1);
    end

    // Outputs are registered one step ahead: each transfer loads the next bit's compare result.
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rng       <= '0;
            r_val       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_val       <= in_value;
                        r_rng       <= '0;
                        r_cnt       <= '0;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_bit   <= (in_value != '0);
                        r_out_last  <= 1'b0;
                        r_state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_transfer) begin
                        r_cnt <= w_cnt_nxt;
                        r_rng <= w_rng_nxt;
                        if (r_out_last) begin
                            r_state     <= ST_IDLE;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_bit   <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_out_bit  <= (r_val > w_rng_nxt);
                            r_out_last <= w_last_nxt;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_bit   = r_out_bit;
    assign out_last  = r_out_last;

endmodule

// File: doc/sng_frame_gen.md
Name: sng_frame_gen

Overview:
- Binary-to-stochastic encoder with frame delimiting; the transmit-side counterpart of sd_converter.
- Accepts one WIDTH-bit unsigned value per frame over a valid/ready handshake.
- Emits a 2^WIDTH-bit unipolar stochastic stream with a last marker on the final bit. The stream feeds sc_* arithmetic or sd_converter directly.
- Uses an internal LFSR restarted every frame, so the count of ones per frame equals the input value exactly.

Parameters:
- WIDTH, 8, value and RNG width; legal range 4..16.
- SEED, 8'hF3, LFSR start state loaded at each frame start; a value of 0 is replaced by 1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-low reset.
- in_valid  input  1  in_value is presented.
- in_ready  output  1  block can accept a value; high only in IDLE.
- in_value  input  WIDTH  unsigned binary value to encode.
- out_valid  output  1  out_bit and out_last are valid.
- out_ready  input  1  downstream accepts the current bit.
- out_bit  output  1  stochastic stream bit.
- out_last  output  1  marks the final bit of the frame; qualified by out_valid.

Behaviour:
- Reset: when rst is sampled low at a clk edge:
  - out_valid=0, out_bit=0, out_last=0, in_ready=1.
  - State goes to IDLE; bit counter and LFSR are cleared to 0.
  - Any frame in progress is abandoned; no partial-frame completion.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready:
    - latch in_value into val_r;
    - rng <= 0; bit counter cnt <= 0;
    - go to RUN.
  - RUN: in_ready=0, out_valid=1.
    - out_bit = (val_r > rng), unsigned compare.
    - out_last = (cnt == 2^WIDTH-1).
- Transfer rule: a bit is consumed when out_valid&&out_ready at a clk edge. On a transfer:
  - cnt <= cnt+1.
  - RNG advance: if cnt==0, rng <= SEED; otherwise rng steps the LFSR.
  - If out_last, go to IDLE.
- Stall: while out_ready=0 in RUN, out_bit, out_last, rng, cnt and val_r hold unchanged.
- Latency: handshake accepted at edge t; first bit is valid after edge t (visible in cycle t+1).
  - First bit is (val_r > 0).
  - Second bit compares against SEED.
- Frame-to-frame timing:
  - Minimum frame is 2^WIDTH cycles plus 1 IDLE cycle.
  - in_ready is not asserted during the last bit; the next value is accepted in the cycle after the last transfer.
- LFSR: Fibonacci form.
  - Update: rng <= {rng[WIDTH-2:0], fb}.
  - fb = XOR of tap bits, where tap n means rng[n-1].
  - Taps by WIDTH:
    - 4:(4,3)
    - 5:(5,3)
    - 6:(6,5)
    - 7:(7,6)
    - 8:(8,6,5,4)
    - 9:(9,5)
    - 10:(10,7)
    - 11:(11,9)
    - 12:(12,11,10,4)
    - 13:(13,12,11,8)
    - 14:(14,13,12,2)
    - 15:(15,14)
    - 16:(16,15,13,4)
  - Maximal length: the 2^WIDTH-1 steps from SEED visit every nonzero state exactly once.
- Exactness: each frame presents rng=0 once plus every nonzero value once. Ones per frame therefore equal in_value exactly.
  - in_value=0 gives all zeros.
  - in_value=2^WIDTH-1 gives exactly one zero, the bit where rng=2^WIDTH-1.
- Widths: cnt is WIDTH bits. It reaches 2^WIDTH-1 on the last bit, then wraps to 0, which is don't-care since the FSM is in IDLE.
- in_value changes while in RUN are ignored; val_r is used.
- in_valid held high continuously: frames run back to back, separated by 1 IDLE cycle.
- Reset overrides all simultaneous events, including a transfer of the last bit.

Test Plan:
- WIDTH=8, SEED=F3, in_value=15, out_ready=1:
  - in_ready=1 at accept; 256 bits follow.
  - Exactly 15 ones; out_last high only on bit 256.
  - in_ready returns high the cycle after.
- in_value=0 and in_value=255: zero ones and 255 ones respectively.
  - For 255, the single 0 falls on the bit where rng=8'hFF.
  - out_bit for bit 1 is 0 and 1 respectively.
- in_value=100 with out_ready toggled pseudo-randomly (~50%):
  - The accepted bit sequence is identical to the out_ready=1 run; 100 ones.
  - During stalls out_bit, out_last and out_valid are stable.
- Back-to-back: in_valid held high with values 15 then 10:
  - Two frames with 15 and 10 ones.
  - Exactly one IDLE cycle between them (out_valid=0, in_ready=1).
  - The second frame's bit sequence repeats the LFSR order from rng=0, SEED.
- Reset mid-frame: rst low at bit 40 of a value-200 frame:
  - Next cycle out_valid=0, out_last=0, out_bit=0, in_ready=1.
  - A new value 7 accepted afterwards yields a clean 256-bit frame with 7 ones.
- Chained check: four instances (in_value=15, shared handshake) feed sd_converter via out_bit/out_last. The converted count equals 15 at out_last.
